// File: rtl/seq_detect_param_if.sv
// Serial pattern-detector bus: stream input, configuration and match outputs.
// Parameters PAT_W / CNT_W must match the attached seq_detect_param instance.
//   master : drives in, in_valid, cfg_load, pat_in, mask_in, overlap, cnt_clr;
//            observes out, match_cnt
//   slave  : the detector side of the same signals
interface seq_detect_param_if #(
    parameter int unsigned PAT_W = 3,
    parameter int unsigned CNT_W = 8
);
    logic             in;
    logic             in_valid;
    logic             cfg_load;
    logic [PAT_W-1:0] pat_in;
    logic [PAT_W-1:0] mask_in;
    logic             overlap;
    logic             cnt_clr;
    logic             out;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output in, in_valid, cfg_load, pat_in, mask_in, overlap, cnt_clr,
        input  out, match_cnt
    );

    modport slave (
        input  in, in_valid, cfg_load, pat_in, mask_in, overlap, cnt_clr,
        output out, match_cnt
    );
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial bit-pattern detector with don't-care mask, runtime
// overlapping / non-overlapping mode and a one-cycle registered match pulse.
// Optional build macro SEQ_DET_CNT_EN adds a saturating match counter with a
// synchronous clear; without it match_cnt is tied to 0 and cnt_clr is ignored.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : seq_detect_param_if.slave (stream, config strobe, out, match_cnt)
module seq_detect_param #(
    parameter int unsigned        PAT_W   = 3,
    parameter logic [PAT_W-1:0]   PAT_RST = PAT_W'(3'b111),
    parameter int unsigned        CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    seq_detect_param_if.slave bus
);
    localparam int unsigned FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  hist;
    logic [PAT_W-1:0]  hist_nxt;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_nxt;
    logic [PAT_W-1:0]  pat;
    logic [PAT_W-1:0]  mask;
    logic              out_q;

    logic [PAT_W-1:0]  hist_sh_c;
    logic [FILL_W-1:0] fill_inc_c;
    logic              accept_c;
    logic              match_c;

    // State register: history, fill level, pattern/mask, match pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            hist  <= '0;
            fill  <= '0;
            pat   <= PAT_RST;
            mask  <= '1;
            out_q <= 1'b0;
        end else begin
            hist  <= hist_nxt;
            fill  <= fill_nxt;
            out_q <= match_c;
            if (bus.cfg_load) begin
                pat  <= bus.pat_in;
                mask <= bus.mask_in;
            end
        end
    end

    // Next-state: a match is judged on the post-shift history so the pulse
    // lands one clock after the completing bit is sampled
    always_comb begin
        hist_nxt   = hist;
        fill_nxt   = fill;
        hist_sh_c  = {hist[PAT_W-2:0], bus.in};
        fill_inc_c = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
        accept_c   = bus.in_valid && !bus.cfg_load;
        match_c    = accept_c && (fill_inc_c == FILL_FULL) &&
                     (((hist_sh_c ^ pat) & mask) == '0);

        if (bus.cfg_load) begin
            hist_nxt = '0;
            fill_nxt = '0;
        end else if (bus.in_valid) begin
            hist_nxt = hist_sh_c;
            // Non-overlap restarts collection; stale hist is masked by fill
            fill_nxt = (match_c && !bus.overlap) ? '0 : fill_inc_c;
        end
    end

    // Output: registered pulse
    assign bus.out = out_q;

`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0] cnt;

    // Saturating match counter; clear and match together leave a count of one
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (bus.cnt_clr) begin
            cnt <= match_c ? CNT_W'(1) : '0;
        end else if (match_c && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bus.match_cnt = cnt;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = bus.cnt_clr;
    assign bus.match_cnt  = '0;
`endif
endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: three instances share one stream
// (u0: 3-bit/8-bit counter, u1: 4-bit pattern, u2: 3-bit/2-bit counter) with
// per-instance configuration strobes.
module tb_seq_detect_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       d_in;
    logic       d_valid;
    logic       d_ovl;
    logic       d_clr;
    logic [2:0] d_cfg;
    logic [3:0] d_pat;
    logic [3:0] d_mask;

    int checks   = 0;
    int failures = 0;

    seq_detect_param_if #(.PAT_W(3), .CNT_W(8)) if0 ();
    seq_detect_param_if #(.PAT_W(4), .CNT_W(8)) if1 ();
    seq_detect_param_if #(.PAT_W(3), .CNT_W(2)) if2 ();

    assign if0.in = d_in;     assign if1.in = d_in;     assign if2.in = d_in;
    assign if0.in_valid = d_valid; assign if1.in_valid = d_valid; assign if2.in_valid = d_valid;
    assign if0.overlap = d_ovl;    assign if1.overlap = d_ovl;    assign if2.overlap = d_ovl;
    assign if0.cnt_clr = d_clr;    assign if1.cnt_clr = d_clr;    assign if2.cnt_clr = d_clr;
    assign if0.cfg_load = d_cfg[0]; assign if1.cfg_load = d_cfg[1]; assign if2.cfg_load = d_cfg[2];
    assign if0.pat_in = d_pat[2:0];  assign if1.pat_in = d_pat;  assign if2.pat_in = d_pat[2:0];
    assign if0.mask_in = d_mask[2:0]; assign if1.mask_in = d_mask; assign if2.mask_in = d_mask[2:0];

    seq_detect_param #(.PAT_W(3), .PAT_RST(3'b111), .CNT_W(8))
        u0 (.clk(clk), .rst(rst), .bus(if0));
    seq_detect_param #(.PAT_W(4), .PAT_RST(4'b1011), .CNT_W(8))
        u1 (.clk(clk), .rst(rst), .bus(if1));
    seq_detect_param #(.PAT_W(3), .PAT_RST(3'b111), .CNT_W(2))
        u2 (.clk(clk), .rst(rst), .bus(if2));

    typedef struct {
        logic in_b;
        logic valid;
        logic exp_out;
    } vec_t;

    vec_t tbl[$];

    function automatic int ecnt(input int v);
`ifdef SEQ_DET_CNT_EN
        return v;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bitin(input logic b, input logic v);
        d_in    = b;
        d_valid = v;
        tick();
    endtask

    task automatic do_rst();
        rst     = 1'b1;
        d_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic cfg_load(input int sel, input logic [3:0] p, input logic [3:0] m);
        d_cfg   = 3'(1 << sel);
        d_pat   = p;
        d_mask  = m;
        d_valid = 1'b0;
        tick();
        d_cfg = 3'b000;
    endtask

    function automatic logic out_of(input int sel);
        case (sel)
            0:       return if0.out;
            1:       return if1.out;
            default: return if2.out;
        endcase
    endfunction

    task automatic push(input logic b, input logic v, input logic e);
        vec_t r;
        r.in_b    = b;
        r.valid   = v;
        r.exp_out = e;
        tbl.push_back(r);
    endtask

    task automatic run_tbl(input string name, input int sel);
        foreach (tbl[i]) begin
            bitin(tbl[i].in_b, tbl[i].valid);
            chk($sformatf("%s[%0d]", name, i), 32'(out_of(sel)), 32'(tbl[i].exp_out));
        end
    endtask

    initial begin
        logic s1 [14] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                          1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic s3 [7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        rst = 1'b1; d_in = 1'b0; d_valid = 1'b0; d_ovl = 1'b1; d_clr = 1'b0;
        d_cfg = 3'b000; d_pat = 4'b0000; d_mask = 4'b0000;
        tick();
        tick();
        chk("rst_out0", 32'(if0.out), 0);
        chk("rst_out1", 32'(if1.out), 0);
        chk("rst_cnt0", 32'(if0.match_cnt), 0);
        chk("rst_cnt2", 32'(if2.match_cnt), 0);
        rst = 1'b0;

        // Default 111 pattern, overlapping
        tbl.delete();
        for (int i = 0; i < 14; i++) push(s1[i], 1'b1, (i == 4 || i == 11 || i == 12));
        run_tbl("s1_ovl", 0);
        chk("s1_cnt0", 32'(if0.match_cnt), 32'(ecnt(3)));
        chk("s1_cnt2", 32'(if2.match_cnt), 32'(ecnt(3)));

        // Same stream, non-overlapping
        do_rst();
        d_ovl = 1'b0;
        tbl.delete();
        for (int i = 0; i < 14; i++) push(s1[i], 1'b1, (i == 4 || i == 11));
        run_tbl("s2_novl", 0);
        chk("s2_cnt0", 32'(if0.match_cnt), 32'(ecnt(2)));

        // 4-bit pattern 1011
        do_rst();
        cfg_load(1, 4'b1011, 4'b1111);
        d_ovl = 1'b1;
        tbl.delete();
        for (int i = 0; i < 7; i++) push(s3[i], 1'b1, (i == 3 || i == 6));
        run_tbl("s3_ovl", 1);
        cfg_load(1, 4'b1011, 4'b1111);
        d_ovl = 1'b0;
        tbl.delete();
        for (int i = 0; i < 7; i++) push(s3[i], 1'b1, (i == 3));
        run_tbl("s3_novl", 1);

        // Don't-care middle bit: 1x1
        d_ovl = 1'b1;
        cfg_load(0, 4'b0101, 4'b0101);
        tbl.delete();
        push(1, 1, 0); push(1, 1, 0); push(1, 1, 1); push(0, 1, 0); push(0, 1, 0);
        run_tbl("s4_mask", 0);
        cfg_load(0, 4'b0101, 4'b0101);
        tbl.delete();
        push(1, 1, 0); push(0, 1, 0);
        for (int i = 0; i < 5; i++) push(1, 0, 0);
        push(1, 1, 1);
        run_tbl("s4_hold", 0);

        // cfg_load on a completing bit discards it and empties history
        do_rst();
        bitin(1, 1); chk("cfgc_a", 32'(if0.out), 0);
        bitin(1, 1); chk("cfgc_b", 32'(if0.out), 0);
        d_in = 1'b1; d_valid = 1'b1; d_cfg = 3'b001; d_pat = 4'b0111; d_mask = 4'b0111;
        tick();
        d_cfg = 3'b000;
        chk("cfgc_load", 32'(if0.out), 0);
        bitin(1, 1); chk("cfgc_f1", 32'(if0.out), 0);
        bitin(1, 1); chk("cfgc_f2", 32'(if0.out), 0);
        bitin(1, 1); chk("cfgc_f3", 32'(if0.out), 1);

        // Reset mid-pattern loses partial history
        do_rst();
        bitin(1, 1); bitin(1, 1);
        rst = 1'b1; d_in = 1'b1; d_valid = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstm_r", 32'(if0.out), 0);
        bitin(1, 1); chk("rstm_1", 32'(if0.out), 0);
        bitin(1, 1); chk("rstm_2", 32'(if0.out), 0);
        bitin(1, 1); chk("rstm_3", 32'(if0.out), 1);

        // Five matches: 2-bit counter saturates
        do_rst();
        d_ovl = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bitin(1, 1);
            chk($sformatf("sat_out[%0d]", i), 32'(if2.out), 32'(i >= 2));
        end
        chk("sat_cnt0", 32'(if0.match_cnt), 32'(ecnt(5)));
        chk("sat_cnt2", 32'(if2.match_cnt), 32'(ecnt(3)));

        // Clear with a concurrent match
        d_clr = 1'b1;
        bitin(1, 1);
        d_clr = 1'b0;
        chk("clr_out", 32'(if0.out), 1);
        chk("clr_cnt0", 32'(if0.match_cnt), 32'(ecnt(1)));
        chk("clr_cnt2", 32'(if2.match_cnt), 32'(ecnt(1)));
        bitin(0, 1);
        chk("clr_after_out", 32'(if0.out), 0);
        chk("clr_after_cnt", 32'(if0.match_cnt), 32'(ecnt(1)));
        d_clr = 1'b1;
        bitin(0, 0);
        d_clr = 1'b0;
        chk("clr_only", 32'(if0.match_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
Parametrised serial bit-pattern detector that generalises the fixed "111" detector.
- Pattern length, pattern value and don't-care mask are configurable.
- Runtime-selectable overlapping or non-overlapping detection.
- Input-valid qualifier; registered one-cycle match pulse; optional saturating match counter.
- Sits on a serial bit stream in front of framing/sync logic.

Parameters:
PAT_W, 3, pattern length in bits (2..32).
PAT_RST, 3'b111, pattern loaded at reset (width PAT_W).
CNT_W, 8, match counter width.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  reset, synchronous, active-high.
in  input  1  serial data bit.
in_valid  input  1  qualifies in; bit consumed only when 1.
cfg_load  input  1  one-cycle strobe; captures pat_in/mask_in.
pat_in  input  PAT_W  new pattern; bit PAT_W-1 = first-received bit.
mask_in  input  PAT_W  compare mask; 1 = compare, 0 = don't care.
overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
cnt_clr  input  1  synchronous clear of match_cnt.
out  output  1  match pulse, one cycle wide.
match_cnt  output  CNT_W  saturating count of matches.

Behaviour:
- Reset (rst=1 at clk edge):
  - hist=0, fill=0, pat=PAT_RST, mask=all-ones.
  - out=0, match_cnt=0.
  - rst overrides every other input.
- Internal state:
  - hist: PAT_W-bit shift register, oldest bit at MSB.
  - fill: bits-collected counter, saturating at PAT_W, width clog2(PAT_W+1).
- Bit accept (in_valid=1, cfg_load=0):
  - hist <= {hist[PAT_W-2:0], in}.
  - fill <= min(fill+1, PAT_W).
- Match condition: evaluated on the post-shift history, i.e. fill_next==PAT_W and ((hist_next ^ pat) & mask)==0.
- Match timing: out=1 in the cycle after the edge that accepts the completing bit (latency 1 clock from sampling the last bit). Otherwise out=0.
- out never stays high 2 cycles unless consecutive valid bits each complete a match (overlap=1 only).
- Overlap mode (overlap=1): history retained after a match; "1111" with pattern 111 gives 2 matches.
- Non-overlap mode (overlap=0): on a match, fill <= 0 (hist value irrelevant). The next match needs PAT_W fresh bits.
- in_valid=0: hist, fill unchanged; out=0 next cycle.
- cfg_load=1:
  - pat<=pat_in, mask<=mask_in, hist<=0, fill<=0, out<=0 next cycle.
  - A concurrent in_valid bit is discarded; no match is possible in that cycle.
- mask all-zero: matches every valid bit once fill reaches PAT_W (overlap=1). This is legal and not an error.
- overlap is sampled every cycle; changing it mid-stream takes effect on the next accepted bit.
- Counter:
  - match_cnt increments on each match (same edge that sets out), saturating at 2^CNT_W-1.
  - cnt_clr=1 clears it. cnt_clr and a match in the same cycle: result is 1.
- Reset mid-stream: partial history is lost; the first match needs PAT_W new bits.

Optional Feature:
SEQ_DET_CNT_EN
- Defined: match counter and cnt_clr logic present, as above.
- Undefined: no counter flops; match_cnt tied to 0; cnt_clr ignored. out behaviour is identical in both builds.

Test Plan:
1. Reset, defaults (111, overlap=1), in_valid=1, stream 1,0,1,1,1,0,1,1,0,1,1,1,1,0 -> out high after bits 5, 12, 13 (1-based); match_cnt=3.
2. Same stream, overlap=0 -> out high after bits 5, 12 only; match_cnt=2.
3. cfg_load pat_in=4'b1011, mask_in=4'b1111 (PAT_W=4 build), stream 1,0,1,1,0,1,1 -> out after bit 4 and bit 7 (overlap=1); same with overlap=0 -> after bit 4 only.
4. Mask don't-care: pat_in=3'b101, mask_in=3'b101, stream 1,1,1,0,0 -> out after bit 3 only. Then in_valid=0 for 5 cycles mid-pattern -> no out, history held; resume completes the match.
5. Boundaries:
   - cfg_load asserted with in_valid=1 on a completing bit -> no out; fill=0.
   - rst asserted mid-pattern, then 2 ones -> no out.
   - CNT_W=2, 5 matches -> match_cnt saturates at 3.
   - cnt_clr with simultaneous match -> match_cnt=1.
6. Build without SEQ_DET_CNT_EN, rerun scenario 1 -> identical out trace; match_cnt=0 throughout.
